dcm_prog_ctrl: RTL and testbench

- Sequences reprogramming of the dcm slow clock (clk_2) from two user buttons, up and down.
- Holds the target mode and drives the dcm prog_in/update pair for long enough that the dcm's 10 Hz domain samples it.
- Confirms completion by watching the dcm's prog_out, with timeout and error reporting.
- Sits between the board button inputs and the dcm in the top-level.

---
 rtl/dcm_pkg.sv | 42 ++++
 rtl/btn_sync_edge.sv | 29 ++
 rtl/dcm_prog_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dcm_prog_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_pkg.sv
// dcm_pkg: constants, state encoding and the mode-step helper that are shared
// between the dcm and its programming controller.
package dcm_pkg;

   localparam int PROG_W = 3;
   localparam int MODE_MAX_DEF = 7;

   // One 10 Hz period of the dcm slow domain at 100 MHz.
   localparam int HALF_MS_CONT = 10000000;
   localparam int UPDATE_HOLD_DEF = HALF_MS_CONT;
   localparam int ACK_TIMEOUT_DEF = 2 * HALF_MS_CONT;

   localparam logic [PROG_W-1:0] PROG_ONE = PROG_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      ERR  = 2'd3
   } prog_state_e;

   // One up or down step from cur, either saturating or wrapping at the ends.
   function automatic logic [PROG_W-1:0] mode_step(
      input logic [PROG_W-1:0] cur,
      input logic              up,
      input logic              dn,
      input logic [PROG_W-1:0] max_t,
      input logic              wrap
   );
      logic [PROG_W-1:0] nxt;
      nxt = cur;
      if (up) begin
         if (cur >= max_t) nxt = wrap ? '0 : cur;
         else              nxt = cur + PROG_ONE;
      end else if (dn) begin
         if (cur == '0) nxt = wrap ? max_t : cur;
         else           nxt = cur - PROG_ONE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer for a raw button pin followed by a
// registered rising-edge detector. Pin to pulse latency is three clk cycles.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic sync_1;
   logic sync_2;
   logic sync_d;

   // Synchronize the pin, then emit one pulse per synchronized rising edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_d <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_1 <= din;
         sync_2 <= sync_1;
         sync_d <= sync_2;
         rise   <= sync_2 & ~sync_d;
      end
   end

endmodule

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: sequences reprogramming of the dcm slow clock from the up and
// down buttons. Holds update long enough for the 10 Hz domain to sample it and
// waits for prog_out to confirm, flagging a sticky err on timeout.
// Build macro DCM_PROG_CTRL_WRAP_EN: when defined, stepping past MODE_MAX wraps
// to 0 and stepping below 0 wraps to MODE_MAX; otherwise steps saturate.
//
// state | meaning
// IDLE  | nothing outstanding, prog_in equals mode
// REQ   | update high, prog_in frozen, counting UPDATE_HOLD cycles
// WAIT  | update low, waiting for prog_out == prog_in or ACK_TIMEOUT
// ERR   | ack timed out, err set, prog_in reverted to mode
module dcm_prog_ctrl
   import dcm_pkg::*;
#(
   parameter int unsigned UPDATE_HOLD = UPDATE_HOLD_DEF,
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int unsigned MODE_MAX    = MODE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic [PROG_W-1:0] prog_out,
   output logic [PROG_W-1:0] prog_in,
   output logic              update,
   output logic              busy,
   output logic              err,
   output logic [PROG_W-1:0] mode
);

   localparam logic [31:0]       HOLD_LAST = 32'(UPDATE_HOLD - 1);
   localparam logic [31:0]       ACK_LAST  = 32'(ACK_TIMEOUT - 1);
   localparam logic [PROG_W-1:0] MAX_T     = PROG_W'(MODE_MAX);
`ifdef DCM_PROG_CTRL_WRAP_EN
   localparam logic              WRAP      = 1'b1;
`else
   localparam logic              WRAP      = 1'b0;
`endif

   logic              up_rise;
   logic              down_rise;
   logic              ev_up;
   logic              ev_dn;
   logic              ev_any;

   prog_state_e       state_q, state_d;
   logic [PROG_W-1:0] prog_in_q, prog_in_d;
   logic [PROG_W-1:0] mode_q, mode_d;
   logic              err_q, err_d;
   logic [PROG_W-1:0] pend_q, pend_d;
   logic              pend_vld_q, pend_vld_d;
   logic [31:0]       cnt_q, cnt_d;

   logic [PROG_W-1:0] idle_tgt;
   logic              idle_go;
   logic [PROG_W-1:0] latest_tgt;
   logic [PROG_W-1:0] busy_tgt;
   logic              pend_hit;

   btn_sync_edge u_sync_up (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_up),
      .rise (up_rise)
   );

   btn_sync_edge u_sync_down (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_down),
      .rise (down_rise)
   );

   // Simultaneous presses cancel each other.
   assign ev_up  = up_rise & ~down_rise;
   assign ev_dn  = down_rise & ~up_rise;
   assign ev_any = ev_up | ev_dn;

   // From IDLE/ERR the reference is the acknowledged mode; a step that goes
   // nowhere (saturated) is dropped.
   assign idle_tgt = mode_step(mode_q, ev_up, ev_dn, MAX_T, WRAP);
   assign idle_go  = ev_any && (idle_tgt != mode_q);

   // While busy, presses chain off the newest target: pending if one is held,
   // otherwise the one in flight.
   assign latest_tgt = pend_vld_q ? pend_q : prog_in_q;
   assign busy_tgt   = mode_step(latest_tgt, ev_up, ev_dn, MAX_T, WRAP);
   assign pend_hit   = ev_any && (busy_tgt != latest_tgt);

   assign prog_in = prog_in_q;
   assign mode    = mode_q;
   assign err     = err_q;
   assign update  = (state_q == REQ);
   assign busy    = (state_q == REQ) || (state_q == WAIT);

   // State and datapath registers; reset also drops update on the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         prog_in_q  <= '0;
         mode_q     <= '0;
         err_q      <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         prog_in_q  <= prog_in_d;
         mode_q     <= mode_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state, target, pending-slot and counter logic.
   always_comb begin
      state_d    = state_q;
      prog_in_d  = prog_in_q;
      mode_d     = mode_q;
      err_d      = err_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE, ERR: begin
            if (idle_go) begin
               prog_in_d  = idle_tgt;
               err_d      = 1'b0;
               cnt_d      = '0;
               pend_vld_d = 1'b0;
               state_d    = REQ;
            end
         end

         REQ: begin
            if (pend_hit) begin
               pend_d     = busy_tgt;
               pend_vld_d = 1'b1;
            end
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         WAIT: begin
            if (pend_hit) begin
               pend_d     = busy_tgt;
               pend_vld_d = 1'b1;
            end
            if (prog_out == prog_in_q) begin
               mode_d = prog_in_q;
               // A pending target equal to the mode just acked needs no resend.
               if (pend_vld_d && (pend_d != prog_in_q)) begin
                  prog_in_d = pend_d;
                  cnt_d     = '0;
                  state_d   = REQ;
               end else begin
                  state_d = IDLE;
               end
               pend_vld_d = 1'b0;
            end else if (cnt_q == ACK_LAST) begin
               err_d      = 1'b1;
               prog_in_d  = mode_q;
               pend_vld_d = 1'b0;
               state_d    = ERR;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
`timescale 1ns/1ps
module tb_dcm_prog_ctrl;

   localparam int HOLD = 4;
   localparam int TO   = 16;
   localparam int MMAX = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [2:0] prog_out = 3'd0;
   logic [2:0] prog_in;
   logic       update;
   logic       busy;
   logic       err;
   logic [2:0] mode;

   dcm_prog_ctrl #(
      .UPDATE_HOLD (HOLD),
      .ACK_TIMEOUT (TO),
      .MODE_MAX    (MMAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .prog_out (prog_out),
      .prog_in  (prog_in),
      .update   (update),
      .busy     (busy),
      .err      (err),
      .mode     (mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      int prog;
      int len;
      bit acks;
      bit chain;
      bit abort;
      int revert;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad = 0;
   bit   ack_en = 1'b1;
   int   mode_ref = 0;
   bit   err_ref = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Reference: one step in the mode ring, saturating or wrapping.
   function automatic int ref_step(input int cur, input int dir);
`ifdef DCM_PROG_CTRL_WRAP_EN
      return (cur + dir + MMAX + 1) % (MMAX + 1);
`else
      if (cur + dir > MMAX) return MMAX;
      if (cur + dir < 0) return 0;
      return cur + dir;
`endif
   endfunction

   // dcm model: copies prog_in to prog_out three cycles after update falls.
   bit upd_seen = 1'b0;
   int dly = 0;
   always @(negedge clk) begin
      if (!rst) begin
         prog_out = 3'd0;
         dly = 0;
         upd_seen = 1'b0;
      end else begin
         if (upd_seen && update === 1'b0 && ack_en) dly = 3;
         else if (dly > 0) begin
            dly--;
            if (dly == 0) prog_out = prog_in;
         end
         upd_seen = (update === 1'b1);
      end
   end

   // Monitor: measures each update pulse and its outcome against the queue.
   initial begin : monitor
      exp_t       e;
      logic [2:0] cap;
      int         len;
      int         k;
      bit         unstable;
      forever begin
         if (update !== 1'b1) @(negedge clk);
         else begin
            cap = prog_in;
            len = 0;
            unstable = 1'b0;
            chk("err_clear_at_start", err, 0);
            while (update === 1'b1 && len < 100) begin
               if (prog_in !== cap) unstable = 1'b1;
               len++;
               @(negedge clk);
            end
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_update prog_in=%0d len=%0d required=none", cap, len);
            end else begin
               e = expq.pop_front();
               chk("prog_in", cap, e.prog);
               chk("update_len", len, e.len);
               chk("prog_in_stable", unstable, 0);
               if (e.abort) begin
                  chk("rst_busy", busy, 0);
                  chk("rst_prog_in", prog_in, 0);
                  chk("rst_mode", mode, 0);
                  chk("rst_err", err, 0);
               end else begin
                  k = 0;
                  while (k < 40 && err !== 1'b1 && update !== 1'b1 && busy === 1'b1) begin
                     k++;
                     @(negedge clk);
                  end
                  if (e.acks) begin
                     chk("ack_cycles", k, 4);
                     chk("ack_mode", mode, e.prog);
                     chk("ack_err", err, 0);
                     chk("chain_busy", busy, e.chain);
                     chk("chain_update", update, e.chain);
                  end else begin
                     chk("timeout_cycles", k, TO);
                     chk("timeout_err", err, 1);
                     chk("timeout_busy", busy, 0);
                     chk("timeout_revert", prog_in, e.revert);
                     chk("timeout_mode", mode, e.revert);
                  end
               end
            end
         end
      end
   end

   task automatic press(input bit u, input bit d);
      @(negedge clk);
      btn_up = u;
      btn_down = d;
      @(negedge clk);
      btn_up = 1'b0;
      btn_down = 1'b0;
   endtask

   task automatic settle();
      int n;
      repeat (6) @(negedge clk);
      n = 0;
      while ((busy !== 1'b0 || update !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL settle_timeout busy=%0d required=0", busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_idle(input string pfx);
      chk({pfx, "_mode"}, mode, mode_ref);
      chk({pfx, "_prog_in"}, prog_in, mode_ref);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_update"}, update, 0);
      chk({pfx, "_err"}, err, err_ref);
   endtask

   // kind: 0 up, 1 down, 2 both at once.
   task automatic do_step(input int kind, input bit ack);
      int   t;
      exp_t e;
      ack_en = ack;
      t = (kind == 2) ? mode_ref : ref_step(mode_ref, (kind == 0) ? 1 : -1);
      if (t != mode_ref) begin
         e.prog = t; e.len = HOLD; e.acks = ack; e.chain = 1'b0;
         e.abort = 1'b0; e.revert = mode_ref;
         expq.push_back(e);
         if (ack) begin
            mode_ref = t;
            err_ref = 1'b0;
         end else begin
            err_ref = 1'b1;
         end
      end
      press(kind != 1, kind != 0);
      settle();
      check_idle("step");
   endtask

   // First press starts a transaction; extra presses land while busy.
   task automatic do_burst(input int first_dir, input int n, input logic [2:0] up_mask);
      int   t1;
      int   latest;
      exp_t e;
      ack_en = 1'b1;
      t1 = ref_step(mode_ref, first_dir);
      latest = t1;
      for (int i = 0; i < n; i++) latest = ref_step(latest, up_mask[i] ? 1 : -1);
      e.prog = t1; e.len = HOLD; e.acks = 1'b1; e.chain = (latest != t1);
      e.abort = 1'b0; e.revert = mode_ref;
      expq.push_back(e);
      if (latest != t1) begin
         e.prog = latest; e.chain = 1'b0; e.revert = t1;
         expq.push_back(e);
      end
      mode_ref = latest;
      err_ref = 1'b0;
      press(first_dir == 1, first_dir == -1);
      for (int i = 0; i < n; i++) press(up_mask[i], !up_mask[i]);
      settle();
      check_idle("burst");
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog_expired time=%0t required=finish", $time);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin : stim
      int   dir;
      int   t;
      int   n;
      exp_t e;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      do_step(1, 1'b1);               // down from 0
      do_step(0, 1'b1);               // up
      do_step(1, 1'b1);               // back down
      do_burst(1, 3, 3'b111);         // up, then three ups while busy
      do_step(2, 1'b1);               // both buttons together
      do_step((ref_step(mode_ref, 1) != mode_ref) ? 0 : 1, 1'b0);  // no ack
      do_step(0, 1'b1);               // next press clears err

      for (int i = 0; i < 30; i++)
         do_step($urandom_range(0, 2), $urandom_range(0, 3) != 0);

      for (int i = 0; i < 6; i++) begin
         dir = (ref_step(mode_ref, 1) != mode_ref) ? 1 : -1;
         do_burst(dir, $urandom_range(1, 3), 3'($urandom_range(0, 7)));
      end

      // Reset during the second cycle of REQ.
      ack_en = 1'b1;
      dir = (ref_step(mode_ref, 1) != mode_ref) ? 1 : -1;
      t = ref_step(mode_ref, dir);
      e.prog = t; e.len = 2; e.acks = 1'b1; e.chain = 1'b0;
      e.abort = 1'b1; e.revert = 0;
      expq.push_back(e);
      press(dir == 1, dir == -1);
      n = 0;
      while (update !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_update_seen", n < 20, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mode_ref = 0;
      err_ref = 1'b0;
      repeat (20) @(negedge clk);
      check_idle("post_rst");

      do_step(0, 1'b1);

      chk("queue_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
